// File: rtl/combination_argmax.sv
`default_nettype none
// ============================================================================
// Module   : combination_argmax
// Brief    : Aggregates product rows over self and both COO edge directions,
//            then registers the per-node argmax column index.
// Revision : 1.0
// ============================================================================
module combination_argmax #(
  parameter int FEATURE_ROWS          = 6,
  parameter int WEIGHT_COLS           = 3,
  parameter int DOT_PROD_WIDTH        = 16,
  parameter int NUM_OF_NODES          = 6,
  parameter int COO_NUM_OF_COLS       = 6,
  parameter int COO_BW                = $clog2(COO_NUM_OF_COLS),
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int MAX_ADDRESS_WIDTH     = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic [COO_BW-1:0]                coo_in          [0:1],
  input  logic [DOT_PROD_WIDTH-1:0]        FM_WM_ROW       [0:WEIGHT_COLS-1],
  output logic [COO_BW-1:0]                coo_address,
  output logic [COUNTER_FEATURE_WIDTH-1:0] read_fm_wm_row,
  output logic                             done,
  output logic [MAX_ADDRESS_WIDTH-1:0]     max_addi_answer [0:FEATURE_ROWS-1]
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_SELF     = 3'd1;
  localparam logic [2:0] c_EDGE_SRC = 3'd2;
  localparam logic [2:0] c_EDGE_DST = 3'd3;
  localparam logic [2:0] c_ARGMAX   = 3'd4;
  localparam logic [2:0] c_DONE     = 3'd5;

  logic [2:0]                         state_q, state_d;
  logic [COUNTER_FEATURE_WIDTH-1:0]   node_q, node_d;
  logic [COO_BW-1:0]                  edge_q, edge_d;
  logic [DOT_PROD_WIDTH-1:0]          acc_q [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1];
  logic [DOT_PROD_WIDTH-1:0]          acc_d [0:NUM_OF_NODES-1][0:WEIGHT_COLS-1];
  logic [MAX_ADDRESS_WIDTH-1:0]       ans_q [0:FEATURE_ROWS-1];
  logic [MAX_ADDRESS_WIDTH-1:0]       w_arg [0:FEATURE_ROWS-1];
  logic [DOT_PROD_WIDTH-1:0]          w_best;
  logic                               w_node_last;
  logic                               w_edge_last;
  logic                               w_edge_ok;

  assign w_node_last = (node_q == COUNTER_FEATURE_WIDTH'(NUM_OF_NODES - 1));
  assign w_edge_last = (edge_q == COO_BW'(COO_NUM_OF_COLS - 1));

  // Self-loops and out-of-range endpoints still take both edge cycles but add nothing.
  assign w_edge_ok = (coo_in[0] != coo_in[1])
                  && (int'(coo_in[0]) < NUM_OF_NODES)
                  && (int'(coo_in[1]) < NUM_OF_NODES);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= c_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE, c_DONE: if (start) state_d = c_SELF;
      c_SELF:         if (w_node_last) state_d = c_EDGE_SRC;
      c_EDGE_SRC:     state_d = c_EDGE_DST;
      c_EDGE_DST:     state_d = w_edge_last ? c_ARGMAX : c_EDGE_SRC;
      c_ARGMAX:       state_d = c_DONE;
      default:        state_d = c_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    coo_address    = '0;
    read_fm_wm_row = '0;
    done           = 1'b0;
    case (state_q)
      c_SELF: begin
        read_fm_wm_row = node_q;
      end
      c_EDGE_SRC: begin
        coo_address    = edge_q;
        read_fm_wm_row = COUNTER_FEATURE_WIDTH'(coo_in[0]);
      end
      c_EDGE_DST: begin
        coo_address    = edge_q;
        read_fm_wm_row = COUNTER_FEATURE_WIDTH'(coo_in[1]);
      end
      c_DONE: begin
        done = 1'b1;
      end
      default: begin
        done = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Counters and accumulators
  // --------------------------------------------------------------------------
  always_comb begin
    node_d = node_q;
    edge_d = edge_q;
    acc_d  = acc_q;
    case (state_q)
      c_IDLE, c_DONE: begin
        if (start) begin
          node_d = '0;
          edge_d = '0;
        end
      end
      c_SELF: begin
        node_d = w_node_last ? '0 : node_q + 1'b1;
        for (int n = 0; n < NUM_OF_NODES; n++) begin
          for (int c = 0; c < WEIGHT_COLS; c++) begin
            if (int'(node_q) == n) acc_d[n][c] = FM_WM_ROW[c];
          end
        end
      end
      // Source row is added into the destination node's accumulator.
      c_EDGE_SRC: begin
        for (int n = 0; n < NUM_OF_NODES; n++) begin
          for (int c = 0; c < WEIGHT_COLS; c++) begin
            if (w_edge_ok && (int'(coo_in[1]) == n)) begin
              acc_d[n][c] = acc_q[n][c] + FM_WM_ROW[c];
            end
          end
        end
      end
      c_EDGE_DST: begin
        edge_d = w_edge_last ? '0 : edge_q + 1'b1;
        for (int n = 0; n < NUM_OF_NODES; n++) begin
          for (int c = 0; c < WEIGHT_COLS; c++) begin
            if (w_edge_ok && (int'(coo_in[0]) == n)) begin
              acc_d[n][c] = acc_q[n][c] + FM_WM_ROW[c];
            end
          end
        end
      end
      default: begin
        node_d = node_q;
      end
    endcase
  end

  // Strict greater-than keeps the lowest column index on ties.
  always_comb begin
    w_best = '0;
    for (int n = 0; n < FEATURE_ROWS; n++) begin
      w_arg[n] = '0;
      w_best   = acc_q[n][0];
      for (int c = 1; c < WEIGHT_COLS; c++) begin
        if (acc_q[n][c] > w_best) begin
          w_best   = acc_q[n][c];
          w_arg[n] = MAX_ADDRESS_WIDTH'(c);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      node_q <= '0;
      edge_q <= '0;
      for (int n = 0; n < NUM_OF_NODES; n++) begin
        for (int c = 0; c < WEIGHT_COLS; c++) begin
          acc_q[n][c] <= '0;
        end
      end
      for (int n = 0; n < FEATURE_ROWS; n++) begin
        ans_q[n] <= '0;
      end
    end else begin
      node_q <= node_d;
      edge_q <= edge_d;
      acc_q  <= acc_d;
      if (state_q == c_ARGMAX) begin
        for (int n = 0; n < FEATURE_ROWS; n++) begin
          ans_q[n] <= w_arg[n];
        end
      end
    end
  end

  assign max_addi_answer = ans_q;

endmodule
`default_nettype wire
